operand_sel_stage: RTL and testbench

OPERAND_SEL_STAGE -- requirements
Module: operand_sel_stage

---
 rtl/operand_sel_stage.sv | 114 +++++++++++
 tb/tb_operand_sel_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sel_stage.sv
// Operand select stage: per-channel source mux feeding the EXE-side operand
// register, with a per-channel WB hold buffer that keeps a WB-forwarded value
// alive across a stall.
module operand_sel_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_OPS = 2,
    parameter bit          FWD_EN  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [NUM_OPS*DATA_W-1:0]   rs_data,
    input  logic [NUM_OPS*3-1:0]        src_sel,
    input  logic [DATA_W-1:0]           pc,
    input  logic [DATA_W-1:0]           imm,
    input  logic [DATA_W-1:0]           mem_fwd_data,
    input  logic [DATA_W-1:0]           wb_fwd_data,
    output logic                        out_valid,
    output logic [NUM_OPS*DATA_W-1:0]   op_data,
    output logic [NUM_OPS-1:0]          hold_active,
    output logic [15:0]                 stall_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_RS  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_PC  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_IMM = 3'd2;
    localparam logic [SEL_W-1:0] SEL_MEM = 3'd3;
    localparam logic [SEL_W-1:0] SEL_WB  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                      out_valid_q,   out_valid_d;
    logic [NUM_OPS*DATA_W-1:0] op_data_q,     op_data_d;
    logic [NUM_OPS-1:0]        hold_active_q, hold_active_d;
    logic [NUM_OPS*DATA_W-1:0] hold_reg_q,    hold_reg_d;
    logic [CNT_W-1:0]          stall_cnt_q,   stall_cnt_d;
    logic [NUM_OPS*DATA_W-1:0] sel_data_c;

    // Per-channel source mux; WB source prefers the hold buffer when it is live
    always_comb begin
        sel_data_c = '0;
        for (int c = 0; c < NUM_OPS; c++) begin
            unique case (src_sel[c*SEL_W +: SEL_W])
                SEL_RS:  sel_data_c[c*DATA_W +: DATA_W] = rs_data[c*DATA_W +: DATA_W];
                SEL_PC:  sel_data_c[c*DATA_W +: DATA_W] = pc;
                SEL_IMM: sel_data_c[c*DATA_W +: DATA_W] = imm;
                SEL_MEM: sel_data_c[c*DATA_W +: DATA_W] = FWD_EN ? mem_fwd_data
                                                                 : rs_data[c*DATA_W +: DATA_W];
                SEL_WB:  sel_data_c[c*DATA_W +: DATA_W] = !FWD_EN ? rs_data[c*DATA_W +: DATA_W]
                                                        : hold_active_q[c] ? hold_reg_q[c*DATA_W +: DATA_W]
                                                                           : wb_fwd_data;
                default: sel_data_c[c*DATA_W +: DATA_W] = '0;
            endcase
        end
    end

    // Next-state: flush kills, stall holds (and captures WB), otherwise advance
    always_comb begin
        out_valid_d   = out_valid_q;
        op_data_d     = op_data_q;
        hold_active_d = hold_active_q;
        hold_reg_d    = hold_reg_q;
        stall_cnt_d   = stall_cnt_q;

        if (flush) begin
            out_valid_d   = 1'b0;
            hold_active_d = '0;
        end else if (stall) begin
            for (int c = 0; c < NUM_OPS; c++) begin
                if (FWD_EN && in_valid && !hold_active_q[c] &&
                    (src_sel[c*SEL_W +: SEL_W] == SEL_WB)) begin
                    hold_reg_d[c*DATA_W +: DATA_W] = wb_fwd_data;
                    hold_active_d[c]               = 1'b1;
                end
            end
        end else begin
            op_data_d     = sel_data_c;
            out_valid_d   = in_valid;
            hold_active_d = '0;
        end

        if (stall && out_valid_q && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            op_data_q     <= '0;
            hold_active_q <= '0;
            hold_reg_q    <= '0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            op_data_q     <= op_data_d;
            hold_active_q <= hold_active_d;
            hold_reg_q    <= hold_reg_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign op_data     = op_data_q;
    assign hold_active = hold_active_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed bench for operand_sel_stage: one forwarding-enabled instance and
// one forwarding-disabled instance sharing the same stimulus.
module tb_operand_sel_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_OPS = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      stall;
    logic                      flush;
    logic [NUM_OPS*DATA_W-1:0] rs_data;
    logic [NUM_OPS*3-1:0]      src_sel;
    logic [DATA_W-1:0]         pc;
    logic [DATA_W-1:0]         imm;
    logic [DATA_W-1:0]         mem_fwd_data;
    logic [DATA_W-1:0]         wb_fwd_data;

    logic                      out_valid0,   out_valid1;
    logic [NUM_OPS*DATA_W-1:0] op_data0,     op_data1;
    logic [NUM_OPS-1:0]        hold_active0, hold_active1;
    logic [15:0]               stall_cnt0,   stall_cnt1;

    int checks = 0;
    int errors = 0;

    operand_sel_stage #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .FWD_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_data(rs_data), .src_sel(src_sel), .pc(pc), .imm(imm),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid0), .op_data(op_data0), .hold_active(hold_active0),
        .stall_cnt(stall_cnt0)
    );

    operand_sel_stage #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .FWD_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_data(rs_data), .src_sel(src_sel), .pc(pc), .imm(imm),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid1), .op_data(op_data1), .hold_active(hold_active1),
        .stall_cnt(stall_cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        rs_data = '0; src_sel = '0; pc = '0; imm = '0;
        mem_fwd_data = '0; wb_fwd_data = '0;
        #2;
        checks++;
        if ({out_valid0, op_data0, hold_active0, stall_cnt0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0 got %h want 0", {out_valid0, op_data0, hold_active0, stall_cnt0});
        end
        checks++;
        if ({out_valid1, op_data1, hold_active1, stall_cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 got %h want 0", {out_valid1, op_data1, hold_active1, stall_cnt1});
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_valid got %b want 0", out_valid0);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1;
        src_sel  = {3'd2, 3'd1};
        pc       = 32'h0000_0100;
        imm      = 32'hFFFF_FFF0;
        tick();
        checks++;
        if (out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid got %b want 1", out_valid0);
        end
        checks++;
        if (op_data0 !== {32'hFFFF_FFF0, 32'h0000_0100}) begin
            errors++;
            $display("FAIL basic_pc_imm got %h want %h", op_data0, {32'hFFFF_FFF0, 32'h0000_0100});
        end
        rs_data      = {32'h0, 32'h1111_1111};
        mem_fwd_data = 32'h0000_2222;
        src_sel      = {3'd3, 3'd0};
        tick();
        checks++;
        if (op_data0 !== {32'h0000_2222, 32'h1111_1111}) begin
            errors++;
            $display("FAIL basic_rs_mem got %h want %h", op_data0, {32'h0000_2222, 32'h1111_1111});
        end
    endtask

    task automatic test_hold();
        logic [7:0] wb_seq [3];
        wb_seq[0] = 8'hAA; wb_seq[1] = 8'hBB; wb_seq[2] = 8'hCC;
        rs_data = {32'h0000_3333, 32'h1111_1111};
        src_sel = {3'd0, 3'd4};
        stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_fwd_data = 32'(wb_seq[i]);
            tick();
            checks++;
            if (hold_active0 !== 2'b01) begin
                errors++;
                $display("FAIL hold_active_stall%0d got %b want 01", i, hold_active0);
            end
            checks++;
            if (op_data0 !== {32'h0000_2222, 32'h1111_1111}) begin
                errors++;
                $display("FAIL hold_op_frozen%0d got %h want %h", i, op_data0, {32'h0000_2222, 32'h1111_1111});
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (op_data0 !== {32'h0000_3333, 32'h0000_00AA}) begin
            errors++;
            $display("FAIL hold_release_op got %h want %h", op_data0, {32'h0000_3333, 32'h0000_00AA});
        end
        checks++;
        if (hold_active0 !== 2'b00) begin
            errors++;
            $display("FAIL hold_release_active got %b want 00", hold_active0);
        end
        checks++;
        if (stall_cnt0 !== 16'd3) begin
            errors++;
            $display("FAIL hold_stall_cnt got %0d want 3", stall_cnt0);
        end
    endtask

    task automatic test_flush();
        wb_fwd_data = 32'h0000_00DD;
        stall = 1'b1;
        tick();
        checks++;
        if (hold_active0 !== 2'b01) begin
            errors++;
            $display("FAIL flush_pre_hold got %b want 01", hold_active0);
        end
        flush = 1'b1;
        tick();
        checks++;
        if (out_valid0 !== 1'b0 || hold_active0 !== 2'b00) begin
            errors++;
            $display("FAIL flush_kill got valid=%b hold=%b want 0 00", out_valid0, hold_active0);
        end
        checks++;
        if (op_data0 !== {32'h0000_3333, 32'h0000_00AA}) begin
            errors++;
            $display("FAIL flush_op_hold got %h want %h", op_data0, {32'h0000_3333, 32'h0000_00AA});
        end
        checks++;
        if (stall_cnt0 !== 16'd5) begin
            errors++;
            $display("FAIL flush_stall_cnt got %0d want 5", stall_cnt0);
        end
        flush = 1'b0;
        stall = 1'b0;
        tick();
    endtask

    task automatic test_const_nofwd();
        rs_data = {32'h0000_DEAD, 32'h0000_DEAD};
        src_sel = {3'd7, 3'd5};
        tick();
        checks++;
        if (op_data0 !== '0 || op_data1 !== '0) begin
            errors++;
            $display("FAIL const_zero got %h / %h want 0", op_data0, op_data1);
        end
        rs_data      = {32'h0000_0066, 32'h0000_0055};
        mem_fwd_data = 32'h0000_0077;
        wb_fwd_data  = 32'h0000_0088;
        src_sel      = {3'd4, 3'd3};
        tick();
        checks++;
        if (op_data1 !== {32'h0000_0066, 32'h0000_0055}) begin
            errors++;
            $display("FAIL nofwd_rs got %h want %h", op_data1, {32'h0000_0066, 32'h0000_0055});
        end
        checks++;
        if (op_data0 !== {32'h0000_0088, 32'h0000_0077}) begin
            errors++;
            $display("FAIL fwd_mem_wb got %h want %h", op_data0, {32'h0000_0088, 32'h0000_0077});
        end
        stall = 1'b1;
        tick();
        checks++;
        if (hold_active0 !== 2'b10 || hold_active1 !== 2'b00) begin
            errors++;
            $display("FAIL hold_per_channel got %b / %b want 10 / 00", hold_active0, hold_active1);
        end
    endtask

    task automatic test_reset_mid_hold();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid0, op_data0, hold_active0, stall_cnt0} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", {out_valid0, op_data0, hold_active0, stall_cnt0});
        end
        src_sel     = {3'd4, 3'd1};
        pc          = 32'h0000_0100;
        wb_fwd_data = 32'h0000_0099;
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (hold_active0 !== 2'b10 || out_valid0 !== 1'b0 || stall_cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_capture got hold=%b valid=%b cnt=%0d want 10 0 0",
                     hold_active0, out_valid0, stall_cnt0);
        end
        wb_fwd_data = 32'h0000_00A0;
        stall = 1'b0;
        tick();
        checks++;
        if (op_data0 !== {32'h0000_0099, 32'h0000_0100} || out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_release got %h valid=%b want %h 1",
                     op_data0, out_valid0, {32'h0000_0099, 32'h0000_0100});
        end
    endtask

    task automatic test_stall_sat();
        src_sel = '0;
        stall   = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        checks++;
        if (stall_cnt0 !== 16'hFFFE) begin
            errors++;
            $display("FAIL stall_cnt_fffe got %h want fffe", stall_cnt0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (stall_cnt0 !== 16'hFFFF) begin
                errors++;
                $display("FAIL stall_cnt_sat%0d got %h want ffff", i, stall_cnt0);
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flush();
        test_const_nofwd();
        test_reset_mid_hold();
        test_stall_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
